pwm_ramp_ctrl: RTL

Soft-start / slew controller that sequences the duty input of the variable PWM generator. It accepts a target duty, step size and dwell time through a valid/ready command port. It walks its registered duty output toward the target in frame-aligned steps, so the PWM never sees a duty change mid-period. It sits between the host/register interface and the PWM block's `duty` input; `frame_sync` comes from the PWM counter wrap.

---
 rtl/pwm_ramp_ctrl_pkg.sv | 15 +
 rtl/pwm_ramp_ctrl_if.sv | 27 ++
 rtl/pwm_ramp_ctrl_frame_dwell_counter.sv | 30 +++
 rtl/pwm_ramp_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared types and constants for the PWM ramp controller and its sub-blocks.
package pwm_ctrl_pkg;

    localparam int R_DEFAULT          = 8;
    localparam int DWELL_BITS_DEFAULT = 8;
    // Full-scale duty (100 %) for the default resolution.
    localparam int DUTY_MAX           = 1 << R_DEFAULT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Command port of the ramp controller.
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; the master holds all cmd_* fields stable while
// cmd_valid is high and not yet accepted, and cmd_ready never depends on
// cmd_valid.
interface pwm_ramp_ctrl_if
    import pwm_ctrl_pkg::*;
#(
    parameter int R         = R_DEFAULT,
    parameter int DwellBits = DWELL_BITS_DEFAULT
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [R:0]           cmd_target;
    logic [R-1:0]         cmd_step;
    logic [DwellBits-1:0] cmd_dwell;

    modport master (
        output cmd_valid, cmd_target, cmd_step, cmd_dwell,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_target, cmd_step, cmd_dwell,
        output cmd_ready
    );
endinterface

// File: rtl/pwm_ramp_ctrl_frame_dwell_counter.sv
// Counts PWM frame pulses and flags the pulse on which the dwell count is
// reached; the count then restarts from zero.
module frame_dwell_counter
    import pwm_ctrl_pkg::*;
#(
    parameter int DwellBits = DWELL_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 frame_sync,
    input  logic [DwellBits-1:0] dwell,
    output logic                 step_now
);
    logic [DwellBits-1:0] count;
    logic [DwellBits:0]   count_next;

    assign count_next = {1'b0, count} + (DwellBits + 1)'(1);
    // >= also makes a zero dwell behave as one frame.
    assign step_now   = frame_sync & ~clear & (count_next >= {1'b0, dwell});

    // Frame counter: held at zero while cleared, wraps when a step fires.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (frame_sync) begin
            count <= step_now ? '0 : count_next[DwellBits-1:0];
        end
    end
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start / slew controller: walks a registered duty toward a commanded
// target in frame-aligned steps so the PWM never sees a mid-period change.
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int R         = R_DEFAULT,
    parameter int DwellBits = DWELL_BITS_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_sync,
    input  logic              abort,
    pwm_ramp_ctrl_if.slave    cmd,
    output logic [R:0]        duty,
    output logic              busy,
    output logic              done,
    output state_t            state
);
    localparam logic [R+1:0] FULL_SCALE = {2'b01, {R{1'b0}}};

    state_t               state_next;
    logic [R:0]           tgt_q;
    logic [R-1:0]         step_q;
    logic [DwellBits-1:0] dwell_q;
    logic                 handshake;
    logic                 step_now;
    logic [R:0]           tgt_sat;
    logic [R:0]           duty_stepped;
    logic [R+1:0]         duty_w, tgt_w, step_w, sum_w, diff_w;

    assign cmd.cmd_ready = (state == IDLE) & ~reset;
    assign handshake     = cmd.cmd_valid & cmd.cmd_ready;
    assign busy          = (state == RAMP);
    assign done          = (state == DONE);
    assign tgt_sat       = ({1'b0, cmd.cmd_target} > FULL_SCALE) ? FULL_SCALE[R:0] : cmd.cmd_target;

    frame_dwell_counter #(.DwellBits(DwellBits)) u_dwell (
        .clk        (clk),
        .reset      (reset),
        .clear      ((state != RAMP) | abort),
        .frame_sync (frame_sync),
        .dwell      (dwell_q),
        .step_now   (step_now)
    );

    // Widened arithmetic so neither direction can wrap or overshoot the target.
    assign duty_w = {1'b0, duty};
    assign tgt_w  = {1'b0, tgt_q};
    assign step_w = {2'b00, step_q};
    assign sum_w  = duty_w + step_w;
    assign diff_w = duty_w - step_w;

    // Next duty one step toward the target, clamped at the target.
    always_comb begin
        duty_stepped = tgt_q;
        if (tgt_w > duty_w) begin
            if (sum_w < tgt_w) duty_stepped = sum_w[R:0];
        end else if (duty_w >= tgt_w + step_w) begin
            duty_stepped = diff_w[R:0];
        end
    end

    // Next-state logic; abort wins over any step in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (handshake) state_next = RAMP;
            RAMP: begin
                if (abort)                                    state_next = IDLE;
                else if (duty == tgt_q)                       state_next = DONE;
                else if (step_now && (duty_stepped == tgt_q)) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Command latch with zero step/dwell promoted to one.
    always_ff @(posedge clk) begin
        if (reset) begin
            tgt_q   <= '0;
            step_q  <= '0;
            dwell_q <= '0;
        end else if (handshake) begin
            tgt_q   <= tgt_sat;
            step_q  <= (cmd.cmd_step == '0) ? R'(1) : cmd.cmd_step;
            dwell_q <= (cmd.cmd_dwell == '0) ? DwellBits'(1) : cmd.cmd_dwell;
        end
    end

    // Duty register: only moves on a dwell-completing frame while ramping.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty <= '0;
        end else if ((state == RAMP) && !abort && step_now) begin
            duty <= duty_stepped;
        end
    end
endmodule
